// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_reg_arbiter
//  Description : Round-robin scheduler that shares one registered output (q)
//                among NREQ requesters using req/gnt ownership. The current
//                owner's data slice is loaded into q on every owned edge where
//                it still requests; dropping req releases the grant.
//                q_comb is a purely combinational copy of q.
//  Ports       : clk       - clock, all state updates on posedge
//                rst       - synchronous reset, active-high
//                req       - request per requester [NREQ]
//                data      - packed requester data, slice i = data[i*WIDTH +: WIDTH]
//                gnt       - registered one-hot grant (zero when idle)
//                owner_id  - index of current / last owner
//                busy      - high while a requester owns q
//                q         - shared register
//                q_comb    - combinational copy of q
//                timeout   - one-cycle pulse after a forced release
//  Options     : ARB_TIMEOUT_EN - when defined, a grant is forcibly released
//                after MAX_HOLD loads and timeout pulses for one cycle.
//                When undefined, timeout is tied low and MAX_HOLD is unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter int               MAX_HOLD  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner_id,
    output logic                      busy,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          q_comb,
    output logic                      timeout
);

    localparam int              c_IDW = $clog2(NREQ);
    localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    if (NREQ < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("shared_reg_arbiter: NREQ must be >= 2 and MAX_HOLD >= 1");
    end

    state_t             r_state;
    logic [c_IDW-1:0]   r_ptr;

    logic [c_IDW-1:0]   w_pick;
    logic               w_pick_found;
    logic [c_IDW-1:0]   w_next_ptr;
    logic               w_own_req;
    logic [WIDTH-1:0]   w_own_data;

    // Round-robin scan starting at r_ptr. Iterating from the farthest
    // offset down to zero lets the nearest requester win the last write.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NREQ]) begin
                w_pick_found = 1'b1;
                w_pick       = c_IDW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    // After a release the owner drops to lowest priority.
    assign w_next_ptr = (owner_id == c_IDW'(NREQ - 1)) ? '0 : owner_id + 1'b1;
    assign w_own_req  = req[owner_id];
    assign w_own_data = data[int'(owner_id)*WIDTH +: WIDTH];

    always_comb begin
        q_comb = q;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_HW = $clog2(MAX_HOLD + 1);

    logic [c_HW-1:0] r_hold;
    logic            w_hold_last;

    // The load performed while hold_cnt == MAX_HOLD-1 is the final one.
    assign w_hold_last = (r_hold == c_HW'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            owner_id <= '0;
            q        <= RESET_VAL;
`ifdef ARB_TIMEOUT_EN
            r_hold   <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        gnt      <= c_ONE << w_pick;
                        owner_id <= w_pick;
                        busy     <= 1'b1;
                        r_state  <= S_OWN;
`ifdef ARB_TIMEOUT_EN
                        r_hold   <= '0;
`endif
                    end
                end
                S_OWN: begin
                    if (w_own_req) begin
                        q <= w_own_data;
`ifdef ARB_TIMEOUT_EN
                        if (r_hold != c_HW'(MAX_HOLD))
                            r_hold <= r_hold + 1'b1;
                        // Forced release on the same edge as the last load.
                        if (w_hold_last) begin
                            gnt     <= '0;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                            r_ptr   <= w_next_ptr;
                            timeout <= 1'b1;
                        end
`endif
                    end else begin
                        // Voluntary release: q keeps its last loaded value.
                        gnt     <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_reg_arbiter
//  Description : Scoreboard bench for shared_reg_arbiter. A reference model
//                tracks owner / pointer / loads per grant and queues the
//                expected outputs after every edge; a monitor pops and
//                compares on the falling edge. Directed phases are followed
//                by randomized requests, data and resets.
//  Options     : ARB_TIMEOUT_EN selects the forced-release expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data;
    logic [NREQ-1:0]         gnt;
    logic [1:0]              owner_id;
    logic                    busy;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        q_comb;
    logic                    timeout;

    shared_reg_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_HOLD  (MAX_HOLD),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .owner_id (owner_id),
        .busy     (busy),
        .q        (q),
        .q_comb   (q_comb),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic             busy;
        logic [1:0]       oid;
        logic [WIDTH-1:0] q;
        logic             to;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: owner is -1 when nobody holds the register.
    int               m_owner = -1;
    int               m_last  = 0;
    int               m_ptr   = 0;
    int               m_loads = 0;
    logic [WIDTH-1:0] m_q     = '0;
    bit               m_to    = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   found;
        cyc++;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_loads = 0; m_q = '0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                found = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req[(m_ptr + i) % NREQ]) begin
                        found   = 1;
                        m_owner = (m_ptr + i) % NREQ;
                        m_last  = m_owner;
                        m_loads = 0;
                    end
                end
            end else if (req[m_owner]) begin
                m_q = data[m_owner*WIDTH +: WIDTH];
                m_loads++;
`ifdef ARB_TIMEOUT_EN
                if (m_loads == MAX_HOLD) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_to    = 1;
                end
`endif
            end else begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        e.gnt  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        e.busy = (m_owner >= 0);
        e.oid  = 2'(m_last);
        e.q    = m_q;
        e.to   = m_to;
        expq.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("gnt",      32'(gnt),      32'(e.gnt));
            chk("busy",     32'(busy),     32'(e.busy));
            chk("owner_id", 32'(owner_id), 32'(e.oid));
            chk("q",        32'(q),        32'(e.q));
            chk("q_comb",   32'(q_comb),   32'(e.q));
            chk("timeout",  32'(timeout),  32'(e.to));
        end
    end

    task automatic idle_cycles(input int n);
        req = '0;
        repeat (n) @(negedge clk);
    endtask

    int cnt [NREQ];

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;

        // Reset for two edges.
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester 2, data 0xA5, dropped after three edges.
        req  = 4'b0100;
        data = '0;
        data[2*WIDTH +: WIDTH] = 8'hA5;
        repeat (3) @(negedge clk);
        req = '0;
        idle_cycles(3);

        // Requesters 0,1,3: each drops req after two loads, then re-requests.
        req = 4'b1011;
        for (int k = 0; k < NREQ; k++) cnt[k] = 0;
        repeat (30) begin
            @(negedge clk);
            data = {$urandom};
            for (int k = 0; k < NREQ; k++) begin
                if (k != 2) begin
                    if (!req[k]) begin
                        req[k] = 1'b1;
                        cnt[k] = 0;
                    end else if (gnt[k]) begin
                        cnt[k]++;
                        if (cnt[k] == 3) req[k] = 1'b0;
                    end
                end
            end
        end
        idle_cycles(3);

        // Requesters 1 and 3 held for 20 edges (forced release when enabled).
        req = 4'b1010;
        repeat (20) begin
            data = {$urandom};
            @(negedge clk);
        end
        idle_cycles(3);

        // Reset while requester 1 owns and q holds 0x3C.
        req  = 4'b0010;
        data = '0;
        data[1*WIDTH +: WIDTH] = 8'h3C;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0101;
        repeat (3) @(negedge clk);
        idle_cycles(3);

        // Requester 0 held for 10 edges.
        req = 4'b0001;
        repeat (10) begin
            data = {$urandom};
            @(negedge clk);
        end
        idle_cycles(3);

        // Randomized requests, data and occasional reset.
        repeat (400) begin
            if ($urandom_range(0, 3) != 0) req = NREQ'($urandom);
            data = {$urandom};
            rst  = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        idle_cycles(3);

        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
